trng_sampler: RTL

// - Downstream consumer of the ring oscillator. Drives its ro_activate and samples its free-running ro_out.
// - Synchronises ro_out into the clk domain, decimates, and applies a von Neumann debiaser.
// - Packs the debiased bits into WIDTH-bit words with a valid/ready output.
// - Runs a sticky repetition-count health test on the raw samples.

---
 rtl/trng_sampler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/trng_sampler.sv
// Ring-oscillator sampler: synchronises ro_in, decimates it, debiases with a von Neumann
// extractor, packs the bits into words behind a valid/ready port, and runs a repetition-count test.
module trng_sampler #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DECIM       = 4,
    parameter int REP_LIMIT   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ro_in,
    output logic             ro_activate,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             health_fail
);

    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam int BCNT_W = $clog2(WIDTH + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        HAVE1 = 1'b1
    } vn_state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [DCNT_W-1:0]      dcnt_reg;
    logic [REP_W-1:0]       rep_reg;
    logic [REP_W-1:0]       rep_next;
    logic                   prev_raw_reg;
    logic                   first_reg;
    logic [WIDTH-1:0]       shreg_reg;
    logic [WIDTH-1:0]       shreg_next;
    logic [BCNT_W-1:0]      bcnt_reg;
    logic [BCNT_W-1:0]      bcnt_next;
    vn_state_t              state_reg;
    vn_state_t              state_next;

    logic sync_q;
    logic raw;
    logic strobe;
    logic trip;
    logic fail_now;
    logic bit_valid;
    logic accept;
    logic transfer;
    logic word_full;
    logic move;

    assign sync_q   = sync_reg[SYNC_STAGES-1];
    assign raw      = sync_q;
    // Strobe is gated by enable so a falling enable swallows a coincident strobe.
    assign strobe   = enable && (dcnt_reg == DCNT_LAST);
    assign transfer = data_valid && data_ready;

    // rep_reg==0 marks the first sample after enable rose; it always restarts the run at 1.
    always_comb begin
        rep_next = rep_reg;
        if (strobe) begin
            if ((rep_reg == '0) || (raw != prev_raw_reg)) begin
                rep_next = REP_W'(1);
            end else if (rep_reg != REP_MAX) begin
                rep_next = rep_reg + 1'b1;
            end
        end
    end

    assign trip     = strobe && (rep_next == REP_MAX);
    assign fail_now = health_fail || trip;

    always_comb begin
        state_next = state_reg;
        bit_valid  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else if (strobe) begin
            case (state_reg)
                IDLE: begin
                    state_next = HAVE1;
                end
                HAVE1: begin
                    state_next = IDLE;
                    bit_valid  = (raw != first_reg);
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // A held full word blocks new bits; they are simply discarded.
    always_comb begin
        accept     = bit_valid && !fail_now && (bcnt_reg != BCNT_FULL);
        shreg_next = shreg_reg;
        bcnt_next  = bcnt_reg;
        if (accept) begin
            shreg_next = {shreg_reg[WIDTH-2:0], first_reg};
            bcnt_next  = bcnt_reg + 1'b1;
        end
        word_full = (bcnt_next == BCNT_FULL);
        move      = enable && word_full && !fail_now && (!data_valid || transfer);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            ro_activate  <= 1'b0;
            dcnt_reg     <= '0;
            rep_reg      <= '0;
            prev_raw_reg <= 1'b0;
            first_reg    <= 1'b0;
            health_fail  <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], ro_in};
            ro_activate <= enable;

            if (!enable || (dcnt_reg == DCNT_LAST)) begin
                dcnt_reg <= '0;
            end else begin
                dcnt_reg <= dcnt_reg + 1'b1;
            end

            rep_reg <= enable ? rep_next : '0;
            if (strobe) begin
                prev_raw_reg <= raw;
            end
            if (strobe && (state_reg == IDLE)) begin
                first_reg <= raw;
            end

            if (!enable) begin
                health_fail <= 1'b0;
            end else if (trip) begin
                health_fail <= 1'b1;
            end
        end
    end

    // Collector and output register; a trip wins over a completing word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_reg  <= '0;
            bcnt_reg   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            shreg_reg <= shreg_next;

            if (!enable || fail_now || move) begin
                bcnt_reg <= '0;
            end else begin
                bcnt_reg <= bcnt_next;
            end

            if (fail_now) begin
                data_valid <= 1'b0;
            end else if (move) begin
                data_out   <= shreg_next;
                data_valid <= 1'b1;
            end else if (transfer) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
